ocw2_priority_control: RTL and testbench
========================================

Name: ocw2_priority_control

Overview:
- Parametrised, clocked successor of the OCW2 end-of-interrupt/rotation logic for the 8259A control block.
- Owns the in-service register (ISR) and the rotation state.
- Decodes OCW2 commands, automatic-EOI and automatic-rotate events into registered ISR clears and priority-rotation updates.
- Sits between the bus/control-logic decoder and the priority resolver; supports NUM_LEVELS interrupt levels instead of a fixed 8.

Parameters:
- NUM_LEVELS, 8, number of interrupt levels; power of two, 2..32.
- LEVEL_W, $clog2(NUM_LEVELS), width of a level index (derived; not overridden).

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- write_initial_command_word_1  input  1  ICW1 write strobe, one cycle.
- auto_eoi_config  input  1  AEOI mode from ICW4.
- write_operation_control_word_2  input  1  OCW2 write strobe, one cycle.
- ocw2_command  input  3  OCW2 bits {R,SL,EOI}.
- ocw2_level  input  LEVEL_W  OCW2 level field.
- acknowledge_set  input  1  first-INTA strobe; sets ISR bit.
- acknowledge_interrupt  input  NUM_LEVELS  one-hot level being acknowledged.
- end_of_acknowledge_sequence  input  1  last-INTA strobe.
- in_service_register  output  NUM_LEVELS  current ISR.
- highest_level_in_service  output  NUM_LEVELS  one-hot highest-priority ISR bit, rotation-aware; zero if ISR empty.
- end_of_interrupt  output  NUM_LEVELS  registered one-cycle mask of bits cleared this cycle.
- auto_rotate_mode  output  1  rotate-in-AEOI enable.
- priority_rotate  output  LEVEL_W  lowest-priority level index.

Behaviour:
- Reset (async) and ICW1 write (sync; highest precedence over all other events): ISR=0, end_of_interrupt=0, auto_rotate_mode=0, priority_rotate=NUM_LEVELS-1.
- Priority order: priority_rotate+1 (mod NUM_LEVELS) is highest, priority_rotate is lowest.
- highest_level_in_service is combinational from ISR and priority_rotate. It is the first set ISR bit scanning upward from priority_rotate+1 with wrap.
- Acknowledged level is latched on acknowledge_set for use at end_of_acknowledge_sequence.
- OCW2 decode on write_operation_control_word_2; all effects visible 1 cycle later:
  - 001 non-specific EOI: clear highest_level_in_service.
  - 011 specific EOI: clear bit ocw2_level.
  - 101 rotate on non-specific EOI: clear highest in service; priority_rotate <= its index.
  - 111 rotate on specific EOI: clear bit ocw2_level; priority_rotate <= ocw2_level.
  - 110 set priority: priority_rotate <= ocw2_level; no clear.
  - 100 auto_rotate_mode <= 1.
  - 000 auto_rotate_mode <= 0.
  - 010 no-op.
- AEOI: end_of_acknowledge_sequence with auto_eoi_config=1 clears the latched level's bit. If auto_rotate_mode=1 as well, priority_rotate <= latched level index.
- ISR next = (ISR & ~clear_mask) | set_mask, where set_mask = acknowledge_interrupt when acknowledge_set=1. Set wins if the same bit is set and cleared in one cycle.
- end_of_interrupt is registered = clear_mask & ISR (bits actually cleared); pulses exactly 1 cycle.
- Non-specific EOI with empty ISR: no clear, end_of_interrupt=0, priority_rotate unchanged (including cmd 101).
- Specific EOI on a level not in service: ISR unchanged, end_of_interrupt=0. Rotate cmd 111 still updates priority_rotate.
- Simultaneous OCW2 and AEOI in one cycle:
  - Clear masks are ORed.
  - For priority_rotate, the AEOI auto-rotate update wins over OCW2.
  - For auto_rotate_mode, the OCW2 update applies; the AEOI rotate decision uses the pre-edge auto_rotate_mode.
- Multi-hot acknowledge_interrupt is illegal; the bench asserts it.

Decomposition:
- Package ocw2_pkg: OCW2 command encodings (EOI_NONSPEC=3'b001, EOI_SPEC=3'b011, ROT_NONSPEC=3'b101, ROT_AEOI_SET=3'b100, ROT_AEOI_CLR=3'b000, ROT_SPEC=3'b111, SET_PRIO=3'b110, NOP=3'b010) and the reset value of priority_rotate.
- One sub-module: rotating_priority_encoder (param NUM_LEVELS). Takes a request vector and rotate index; outputs a one-hot winner and its index. Reused by the interrupt request resolver.

Test Plan:
- Reset, then ack levels 3 and 5 -> ISR=0x28, highest=0x08; OCW2 001 -> next cycle end_of_interrupt=0x08 for 1 cycle, ISR=0x20.
- ISR=0x44, OCW2 101 -> ISR=0x40, priority_rotate=2, highest=0x40.
- OCW2 110 level 4, ack 2 and 6 -> highest=0x40 (order 5,6,7,0,1,2,...); OCW2 011 level 6 -> ISR=0x04.
- auto_eoi_config=1, OCW2 100, ack level 1 + end_of_acknowledge_sequence -> ISR bit 1 cleared, end_of_interrupt=0x02, priority_rotate=1.
- NUM_LEVELS=16: ack level 12, OCW2 111 level 12 -> ISR=0, priority_rotate=12; non-specific EOI on empty ISR -> no change.
- Mid-operation ICW1 write with ack_set on the same cycle -> ISR=0, priority_rotate=7, auto_rotate_mode=0. Async reset asserted between clock edges -> outputs reset immediately.

Source files
------------

// File: rtl/ocw2_pkg.sv
// Shared OCW2 command encodings and reset constants for the 8259A priority
// control slice.
package ocw2_pkg;

  typedef enum logic [2:0] {
    ROT_AEOI_CLR = 3'b000,
    EOI_NONSPEC  = 3'b001,
    NOP          = 3'b010,
    EOI_SPEC     = 3'b011,
    ROT_AEOI_SET = 3'b100,
    ROT_NONSPEC  = 3'b101,
    SET_PRIO     = 3'b110,
    ROT_SPEC     = 3'b111
  } ocw2_cmd_e;

  // After reset the top level is the lowest priority, so level 0 wins.
  function automatic int unsigned prio_reset_value(input int unsigned levels);
    return levels - 32'd1;
  endfunction

endpackage

// File: rtl/ocw2_priority_control_rpe.sv
// Rotating priority encoder: picks the first set request scanning upward from
// rotate+1 with wrap; rotate itself is the lowest priority.
module rotating_priority_encoder #(
  parameter int NUM_LEVELS = 8,
  parameter int LEVEL_W    = $clog2(NUM_LEVELS)
) (
  input  logic [NUM_LEVELS-1:0] request,
  input  logic [LEVEL_W-1:0]    rotate,
  output logic [NUM_LEVELS-1:0] winner,
  output logic [LEVEL_W-1:0]    winner_index,
  output logic                  valid
);

  logic [LEVEL_W-1:0] idx_s;
  logic               hit_s;

  // Scan priority order; the level index wraps naturally at the power-of-two width.
  always_comb begin
    winner       = {NUM_LEVELS{1'b0}};
    winner_index = {LEVEL_W{1'b0}};
    valid        = 1'b0;
    idx_s        = {LEVEL_W{1'b0}};
    hit_s        = 1'b0;
    for (int i = 1; i <= NUM_LEVELS; i++) begin
      idx_s          = rotate + LEVEL_W'(i);
      hit_s          = request[idx_s] & ~valid;
      winner[idx_s]  = winner[idx_s] | hit_s;
      winner_index   = hit_s ? idx_s : winner_index;
      valid          = valid | hit_s;
    end
  end

endmodule

// File: rtl/ocw2_priority_control.sv
// In-service register and rotation state for the 8259A control block: turns
// OCW2 commands and automatic-EOI events into registered ISR clears/rotations.
module ocw2_priority_control
  import ocw2_pkg::*;
#(
  parameter int NUM_LEVELS = 8,
  parameter int LEVEL_W    = $clog2(NUM_LEVELS)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  write_initial_command_word_1,
  input  logic                  auto_eoi_config,
  input  logic                  write_operation_control_word_2,
  input  logic [2:0]            ocw2_command,
  input  logic [LEVEL_W-1:0]    ocw2_level,
  input  logic                  acknowledge_set,
  input  logic [NUM_LEVELS-1:0] acknowledge_interrupt,
  input  logic                  end_of_acknowledge_sequence,
  output logic [NUM_LEVELS-1:0] in_service_register,
  output logic [NUM_LEVELS-1:0] highest_level_in_service,
  output logic [NUM_LEVELS-1:0] end_of_interrupt,
  output logic                  auto_rotate_mode,
  output logic [LEVEL_W-1:0]    priority_rotate
);

  localparam logic [LEVEL_W-1:0]    PRIO_RESET = LEVEL_W'(prio_reset_value(NUM_LEVELS));
  localparam logic [NUM_LEVELS-1:0] ONE_MASK   = NUM_LEVELS'(1);

  logic [NUM_LEVELS-1:0] isr_r;
  logic [NUM_LEVELS-1:0] eoi_r;
  logic                  auto_rotate_r;
  logic [LEVEL_W-1:0]    prio_r;
  logic [LEVEL_W-1:0]    ack_level_r;

  logic [NUM_LEVELS-1:0] hi_onehot_s;
  logic [LEVEL_W-1:0]    hi_index_s;
  logic                  hi_valid_s;
  logic [LEVEL_W-1:0]    ack_index_s;
  logic [NUM_LEVELS-1:0] clear_s;
  logic [NUM_LEVELS-1:0] set_s;
  logic                  rot_load_s;
  logic [LEVEL_W-1:0]    rot_val_s;
  logic                  auto_rotate_next_s;

  rotating_priority_encoder #(
    .NUM_LEVELS (NUM_LEVELS),
    .LEVEL_W    (LEVEL_W)
  ) u_isr_encoder (
    .request      (isr_r),
    .rotate       (prio_r),
    .winner       (hi_onehot_s),
    .winner_index (hi_index_s),
    .valid        (hi_valid_s)
  );

  // One-hot acknowledge vector to level index for the AEOI latch.
  always_comb begin
    ack_index_s = {LEVEL_W{1'b0}};
    for (int i = 0; i < NUM_LEVELS; i++) begin
      ack_index_s = ack_index_s | (acknowledge_interrupt[i] ? LEVEL_W'(i) : {LEVEL_W{1'b0}});
    end
  end

  // Decode OCW2 and AEOI into clear mask, rotation update and mode update.
  always_comb begin
    clear_s            = {NUM_LEVELS{1'b0}};
    rot_load_s         = 1'b0;
    rot_val_s          = prio_r;
    auto_rotate_next_s = auto_rotate_r;
    set_s              = acknowledge_set ? acknowledge_interrupt : {NUM_LEVELS{1'b0}};

    if (write_operation_control_word_2) begin
      case (ocw2_cmd_e'(ocw2_command))
        EOI_NONSPEC: clear_s = hi_onehot_s;
        EOI_SPEC:    clear_s = ONE_MASK << ocw2_level;
        ROT_NONSPEC: begin
          clear_s = hi_onehot_s;
          if (hi_valid_s) begin
            rot_load_s = 1'b1;
            rot_val_s  = hi_index_s;
          end else begin
            rot_load_s = 1'b0;
          end
        end
        ROT_SPEC: begin
          clear_s    = ONE_MASK << ocw2_level;
          rot_load_s = 1'b1;
          rot_val_s  = ocw2_level;
        end
        SET_PRIO: begin
          rot_load_s = 1'b1;
          rot_val_s  = ocw2_level;
        end
        ROT_AEOI_SET: auto_rotate_next_s = 1'b1;
        ROT_AEOI_CLR: auto_rotate_next_s = 1'b0;
        NOP:          clear_s = {NUM_LEVELS{1'b0}};
        default:      clear_s = {NUM_LEVELS{1'b0}};
      endcase
    end else begin
      clear_s = {NUM_LEVELS{1'b0}};
    end

    // AEOI applied last so its rotation overrides any OCW2 rotation this cycle.
    if (end_of_acknowledge_sequence && auto_eoi_config) begin
      clear_s = clear_s | (ONE_MASK << ack_level_r);
      if (auto_rotate_r) begin
        rot_load_s = 1'b1;
        rot_val_s  = ack_level_r;
      end else begin
        rot_load_s = rot_load_s;
      end
    end else begin
      rot_load_s = rot_load_s;
    end
  end

  // State registers; ICW1 behaves as a synchronous reset over everything else.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      isr_r         <= {NUM_LEVELS{1'b0}};
      eoi_r         <= {NUM_LEVELS{1'b0}};
      auto_rotate_r <= 1'b0;
      prio_r        <= PRIO_RESET;
      ack_level_r   <= {LEVEL_W{1'b0}};
    end else if (write_initial_command_word_1) begin
      isr_r         <= {NUM_LEVELS{1'b0}};
      eoi_r         <= {NUM_LEVELS{1'b0}};
      auto_rotate_r <= 1'b0;
      prio_r        <= PRIO_RESET;
      ack_level_r   <= {LEVEL_W{1'b0}};
    end else begin
      isr_r         <= (isr_r & ~clear_s) | set_s;
      eoi_r         <= clear_s & isr_r;
      auto_rotate_r <= auto_rotate_next_s;
      if (rot_load_s) begin
        prio_r <= rot_val_s;
      end
      if (acknowledge_set) begin
        ack_level_r <= ack_index_s;
      end
    end
  end

  assign in_service_register      = isr_r;
  assign highest_level_in_service = hi_onehot_s;
  assign end_of_interrupt         = eoi_r;
  assign auto_rotate_mode         = auto_rotate_r;
  assign priority_rotate          = prio_r;

endmodule

// File: tb/tb_ocw2_priority_control.sv
// Directed bench for ocw2_priority_control: an 8-level and a 16-level instance
// driven from one linear sequence with hand-computed expectations.
module tb_ocw2_priority_control;

  logic        clock;
  logic        reset;

  logic        icw1_8, aeoi_cfg_8, wr_ocw2_8, ack_set_8, eoa_8;
  logic [2:0]  cmd_8;
  logic [2:0]  lvl_8;
  logic [7:0]  ack_8, isr_8, hi_8, eoi_8;
  logic        arm_8;
  logic [2:0]  prio_8;

  logic        icw1_16, aeoi_cfg_16, wr_ocw2_16, ack_set_16, eoa_16;
  logic [2:0]  cmd_16;
  logic [3:0]  lvl_16;
  logic [15:0] ack_16, isr_16, hi_16, eoi_16;
  logic        arm_16;
  logic [3:0]  prio_16;

  int compared = 0;
  int mismatched = 0;

  ocw2_priority_control #(.NUM_LEVELS(8)) dut8 (
    .clock                          (clock),
    .reset                          (reset),
    .write_initial_command_word_1   (icw1_8),
    .auto_eoi_config                (aeoi_cfg_8),
    .write_operation_control_word_2 (wr_ocw2_8),
    .ocw2_command                   (cmd_8),
    .ocw2_level                     (lvl_8),
    .acknowledge_set                (ack_set_8),
    .acknowledge_interrupt          (ack_8),
    .end_of_acknowledge_sequence    (eoa_8),
    .in_service_register            (isr_8),
    .highest_level_in_service       (hi_8),
    .end_of_interrupt               (eoi_8),
    .auto_rotate_mode               (arm_8),
    .priority_rotate                (prio_8)
  );

  ocw2_priority_control #(.NUM_LEVELS(16)) dut16 (
    .clock                          (clock),
    .reset                          (reset),
    .write_initial_command_word_1   (icw1_16),
    .auto_eoi_config                (aeoi_cfg_16),
    .write_operation_control_word_2 (wr_ocw2_16),
    .ocw2_command                   (cmd_16),
    .ocw2_level                     (lvl_16),
    .acknowledge_set                (ack_set_16),
    .acknowledge_interrupt          (ack_16),
    .end_of_acknowledge_sequence    (eoa_16),
    .in_service_register            (isr_16),
    .highest_level_in_service       (hi_16),
    .end_of_interrupt               (eoi_16),
    .auto_rotate_mode               (arm_16),
    .priority_rotate                (prio_16)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Acknowledge vectors must be one-hot whenever the set strobe is high.
  always @(negedge clock) begin
    if (ack_set_8) assert ($onehot(ack_8)) else begin mismatched++; $error("FAIL ack8_onehot observed=%h", ack_8); end
    if (ack_set_16) assert ($onehot(ack_16)) else begin mismatched++; $error("FAIL ack16_onehot observed=%h", ack_16); end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Apply the currently driven inputs for one edge, then drop all strobes.
  task automatic step();
    @(posedge clock);
    #1;
    icw1_8 = 1'b0; wr_ocw2_8 = 1'b0; ack_set_8 = 1'b0; eoa_8 = 1'b0; ack_8 = 8'h00;
    icw1_16 = 1'b0; wr_ocw2_16 = 1'b0; ack_set_16 = 1'b0; eoa_16 = 1'b0; ack_16 = 16'h0000;
  endtask

  task automatic ocw2_8(input logic [2:0] c, input logic [2:0] l);
    wr_ocw2_8 = 1'b1; cmd_8 = c; lvl_8 = l;
  endtask

  task automatic ack8(input logic [7:0] v);
    ack_set_8 = 1'b1; ack_8 = v;
  endtask

  initial begin
    reset = 1'b1;
    icw1_8 = 1'b0; aeoi_cfg_8 = 1'b0; wr_ocw2_8 = 1'b0; ack_set_8 = 1'b0; eoa_8 = 1'b0;
    cmd_8 = 3'b010; lvl_8 = 3'd0; ack_8 = 8'h00;
    icw1_16 = 1'b0; aeoi_cfg_16 = 1'b0; wr_ocw2_16 = 1'b0; ack_set_16 = 1'b0; eoa_16 = 1'b0;
    cmd_16 = 3'b010; lvl_16 = 4'd0; ack_16 = 16'h0000;
    #12;
    reset = 1'b0;
    step();

    chk("rst_isr", 32'(isr_8), 32'h00);
    chk("rst_eoi", 32'(eoi_8), 32'h00);
    chk("rst_arm", 32'(arm_8), 32'h0);
    chk("rst_prio", 32'(prio_8), 32'd7);
    chk("rst_hi", 32'(hi_8), 32'h00);
    chk("rst_prio16", 32'(prio_16), 32'd15);

    ack8(8'h08); step();
    ack8(8'h20); step();
    chk("ack35_isr", 32'(isr_8), 32'h28);
    chk("ack35_hi", 32'(hi_8), 32'h08);
    ocw2_8(3'b001, 3'd0); step();
    chk("nseoi_eoi", 32'(eoi_8), 32'h08);
    chk("nseoi_isr", 32'(isr_8), 32'h20);
    step();
    chk("nseoi_pulse", 32'(eoi_8), 32'h00);

    ocw2_8(3'b011, 3'd5); step();
    chk("seoi5_isr", 32'(isr_8), 32'h00);
    chk("seoi5_eoi", 32'(eoi_8), 32'h20);
    ack8(8'h04); step();
    ack8(8'h40); step();
    ocw2_8(3'b101, 3'd0); step();
    chk("rotns_isr", 32'(isr_8), 32'h40);
    chk("rotns_prio", 32'(prio_8), 32'd2);
    chk("rotns_hi", 32'(hi_8), 32'h40);

    ocw2_8(3'b110, 3'd4); step();
    chk("setprio", 32'(prio_8), 32'd4);
    ack8(8'h04); step();
    chk("prio4_isr", 32'(isr_8), 32'h44);
    chk("prio4_hi", 32'(hi_8), 32'h40);
    ocw2_8(3'b011, 3'd6); step();
    chk("seoi6_isr", 32'(isr_8), 32'h04);
    ocw2_8(3'b011, 3'd3); step();
    chk("seoi_idle_isr", 32'(isr_8), 32'h04);
    chk("seoi_idle_eoi", 32'(eoi_8), 32'h00);

    aeoi_cfg_8 = 1'b1;
    ocw2_8(3'b100, 3'd0); step();
    chk("arm_set", 32'(arm_8), 32'h1);
    ack8(8'h02); step();
    chk("aeoi_pre_isr", 32'(isr_8), 32'h06);
    eoa_8 = 1'b1; step();
    chk("aeoi_isr", 32'(isr_8), 32'h04);
    chk("aeoi_eoi", 32'(eoi_8), 32'h02);
    chk("aeoi_prio", 32'(prio_8), 32'd1);
    chk("aeoi_hi", 32'(hi_8), 32'h04);

    // OCW2 rotate-specific and AEOI together: masks OR, AEOI rotation wins.
    ack8(8'h01); step();
    ocw2_8(3'b111, 3'd2); eoa_8 = 1'b1; step();
    chk("both_isr", 32'(isr_8), 32'h00);
    chk("both_eoi", 32'(eoi_8), 32'h05);
    chk("both_prio", 32'(prio_8), 32'd0);
    ocw2_8(3'b000, 3'd0); step();
    chk("arm_clr", 32'(arm_8), 32'h0);

    // Arming on the same edge as AEOI must not rotate (uses pre-edge mode).
    ack8(8'h10); step();
    ocw2_8(3'b100, 3'd0); eoa_8 = 1'b1; step();
    chk("prearm_isr", 32'(isr_8), 32'h00);
    chk("prearm_prio", 32'(prio_8), 32'd0);
    chk("prearm_arm", 32'(arm_8), 32'h1);
    ocw2_8(3'b000, 3'd0); aeoi_cfg_8 = 1'b0; step();

    ocw2_8(3'b101, 3'd0); step();
    chk("empty_rot_prio", 32'(prio_8), 32'd0);
    chk("empty_rot_eoi", 32'(eoi_8), 32'h00);

    ack8(8'h08); step();
    ocw2_8(3'b100, 3'd0); step();
    icw1_8 = 1'b1; ack8(8'h40); ocw2_8(3'b110, 3'd2); step();
    chk("icw1_isr", 32'(isr_8), 32'h00);
    chk("icw1_prio", 32'(prio_8), 32'd7);
    chk("icw1_arm", 32'(arm_8), 32'h0);
    chk("icw1_eoi", 32'(eoi_8), 32'h00);

    ack8(8'h02); step();
    ack8(8'h02); ocw2_8(3'b011, 3'd1); step();
    chk("setwins_isr", 32'(isr_8), 32'h02);
    chk("setwins_eoi", 32'(eoi_8), 32'h02);

    ack_set_16 = 1'b1; ack_16 = 16'h1000; step();
    chk("l16_isr", 32'(isr_16), 32'h1000);
    chk("l16_hi", 32'(hi_16), 32'h1000);
    wr_ocw2_16 = 1'b1; cmd_16 = 3'b111; lvl_16 = 4'd12; step();
    chk("l16_rot_isr", 32'(isr_16), 32'h0000);
    chk("l16_rot_prio", 32'(prio_16), 32'd12);
    chk("l16_rot_eoi", 32'(eoi_16), 32'h1000);
    wr_ocw2_16 = 1'b1; cmd_16 = 3'b001; lvl_16 = 4'd0; step();
    chk("l16_empty_isr", 32'(isr_16), 32'h0000);
    chk("l16_empty_eoi", 32'(eoi_16), 32'h0000);
    chk("l16_empty_prio", 32'(prio_16), 32'd12);

    ack8(8'h20); step();
    ocw2_8(3'b110, 3'd3); step();
    chk("pre_async_isr", 32'(isr_8), 32'h22);
    #3;
    reset = 1'b1;
    #1;
    chk("async_isr", 32'(isr_8), 32'h00);
    chk("async_prio", 32'(prio_8), 32'd7);
    chk("async_prio16", 32'(prio_16), 32'd15);
    #3;
    reset = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
